// File: rtl/abro_multi_fsm.sv
// N-input ABRO controller: fires once every request line has been seen, holds, re-arms.
// Define ABRO_MULTI_STICKY_EN to keep o high through HOLD instead of a one-cycle pulse.
module abro_multi_fsm #(
    parameter int N       = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     a_in,
    input  logic             r_in,
    output logic             o,
    output logic [3:0]       state,
    output logic [N-1:0]     seen,
    output logic [CNT_W-1:0] fire_count,
    output logic             timeout
);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        COLLECT = 4'b0010,
        FIRE    = 4'b0100,
        HOLD    = 4'b1000
    } state_t;

    // With the timeout disabled the timer is held at zero and folds away.
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t             state_q, state_d;
    logic [N-1:0]       seen_q, seen_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               o_q, o_d;
    logic [N-1:0]       nxt_seen;
    logic               all_seen;

    assign nxt_seen = seen_q | a_in;
    assign all_seen = &nxt_seen;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        seen_d    = seen_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        if (r_in) begin
            state_d = IDLE;
            seen_d  = '0;
            timer_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (a_in != '0) begin
                        seen_d = nxt_seen;
                        if (all_seen) begin
                            state_d = FIRE;
                        end else begin
                            state_d = COLLECT;
                            timer_d = (TIMEOUT > 0) ? TMR_W'(1) : '0;
                        end
                    end
                end
                COLLECT: begin
                    seen_d = nxt_seen;
                    // Completion takes precedence over expiry on the same edge.
                    if (all_seen) begin
                        state_d = FIRE;
                        timer_d = '0;
                    end else if ((TIMEOUT > 0) && (timer_q == TMR_W'(TIMEOUT))) begin
                        state_d   = IDLE;
                        seen_d    = '0;
                        timer_d   = '0;
                        timeout_d = 1'b1;
                    end else if (TIMEOUT > 0) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                FIRE: begin
                    state_d = HOLD;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (a_in == '0) begin
                        state_d = IDLE;
                        seen_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    seen_d  = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    // o is registered from the next state so it never sees a_in/r_in combinationally.
`ifdef ABRO_MULTI_STICKY_EN
    assign o_d = (state_d == FIRE) || (state_d == HOLD);
`else
    assign o_d = (state_d == FIRE);
`endif

    // NOTE: state uses non-blocking assignments and an asynchronous reset of every register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            seen_q    <= '0;
            timer_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            o_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            seen_q    <= seen_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            o_q       <= o_d;
        end
    end

    assign o          = o_q;
    assign state      = state_q;
    assign seen       = seen_q;
    assign fire_count = cnt_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_abro_multi_fsm.sv
// Directed bench for abro_multi_fsm: a TIMEOUT=5/CNT_W=2 instance and a TIMEOUT=0 twin on shared inputs.
module tb_abro_multi_fsm;

    logic       clk;
    logic       reset_n;
    logic [3:0] a_in;
    logic       r_in;

    logic       o, timeout;
    logic [3:0] state, seen;
    logic [1:0] fire_count;

    logic       nt_o, nt_timeout;
    logic [3:0] nt_state, nt_seen;
    logic [7:0] nt_fire_count;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef ABRO_MULTI_STICKY_EN
    localparam logic HOLD_O = 1'b1;
`else
    localparam logic HOLD_O = 1'b0;
`endif

    abro_multi_fsm #(.N(4), .CNT_W(2), .TIMEOUT(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_in       (a_in),
        .r_in       (r_in),
        .o          (o),
        .state      (state),
        .seen       (seen),
        .fire_count (fire_count),
        .timeout    (timeout)
    );

    abro_multi_fsm #(.N(4), .CNT_W(8), .TIMEOUT(0)) dut_nt (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_in       (a_in),
        .r_in       (r_in),
        .o          (nt_o),
        .state      (nt_state),
        .seen       (nt_seen),
        .fire_count (nt_fire_count),
        .timeout    (nt_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_dut(input string tag, input logic [3:0] st, input logic [3:0] sn,
                              input logic o_e, input logic [1:0] fc, input logic to);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_seen"},  32'(seen), 32'(sn));
        check({tag, "_o"},     32'(o), 32'(o_e));
        check({tag, "_count"}, 32'(fire_count), 32'(fc));
        check({tag, "_tmo"},   32'(timeout), 32'(to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        a_in    = 4'h0;
        r_in    = 1'b0;
        #12;
        expect_dut("rst", 4'h1, 4'h0, 1'b0, 2'd0, 1'b0);
        reset_n = 1'b1;

        // One new bit per cycle
        a_in = 4'h1; step(); expect_dut("s1_first", 4'h2, 4'h1, 1'b0, 2'd0, 1'b0);
        a_in = 4'h2; step();
        a_in = 4'h4; step(); expect_dut("s1_third", 4'h2, 4'h7, 1'b0, 2'd0, 1'b0);
        a_in = 4'h8; step(); expect_dut("s1_fire", 4'h4, 4'hF, 1'b1, 2'd0, 1'b0);
        a_in = 4'h0; step(); expect_dut("s1_hold", 4'h8, 4'hF, HOLD_O, 2'd1, 1'b0);
        step();              expect_dut("s1_idle", 4'h1, 4'h0, 1'b0, 2'd1, 1'b0);

        // All bits at once, then held high
        a_in = 4'hF; step(); expect_dut("s2_fire", 4'h4, 4'hF, 1'b1, 2'd1, 1'b0);
        repeat (3) step();   expect_dut("s2_hold", 4'h8, 4'hF, HOLD_O, 2'd2, 1'b0);
        a_in = 4'h0; step(); expect_dut("s2_idle", 4'h1, 4'h0, 1'b0, 2'd2, 1'b0);

        // Timeout expiry after five COLLECT cycles
        a_in = 4'h3; step(); expect_dut("s3_collect", 4'h2, 4'h3, 1'b0, 2'd2, 1'b0);
        a_in = 4'h0; repeat (4) step();
        expect_dut("s3_last", 4'h2, 4'h3, 1'b0, 2'd2, 1'b0);
        step();      expect_dut("s3_expire", 4'h1, 4'h0, 1'b0, 2'd2, 1'b1);
        check("s3_nt_state", 32'(nt_state), 32'h2);
        check("s3_nt_tmo", 32'(nt_timeout), 32'h0);
        step();      expect_dut("s3_pulse_end", 4'h1, 4'h0, 1'b0, 2'd2, 1'b0);
        r_in = 1'b1; step(); r_in = 1'b0;
        check("s3_nt_abort_state", 32'(nt_state), 32'h1);
        check("s3_nt_abort_seen", 32'(nt_seen), 32'h0);

        // Completion on the expiry edge
        a_in = 4'h3; step();
        a_in = 4'h0; repeat (3) step();
        a_in = 4'h4; step(); expect_dut("s4_pre", 4'h2, 4'h7, 1'b0, 2'd2, 1'b0);
        a_in = 4'h8; step(); expect_dut("s4_fire", 4'h4, 4'hF, 1'b1, 2'd2, 1'b0);
        a_in = 4'h0; step(); expect_dut("s4_hold", 4'h8, 4'hF, HOLD_O, 2'd3, 1'b0);
        step();

        // Abort coincident with completion, saturation, abort in HOLD and FIRE
        a_in = 4'h7; step(); expect_dut("s5_collect", 4'h2, 4'h7, 1'b0, 2'd3, 1'b0);
        r_in = 1'b1; a_in = 4'h8; step(); expect_dut("s5_abort", 4'h1, 4'h0, 1'b0, 2'd3, 1'b0);
        r_in = 1'b0; a_in = 4'h0; step(); expect_dut("s5_idle", 4'h1, 4'h0, 1'b0, 2'd3, 1'b0);
        a_in = 4'hF; step(); step();
        expect_dut("s5_sat", 4'h8, 4'hF, HOLD_O, 2'd3, 1'b0);
        r_in = 1'b1; step(); expect_dut("s5_hold_abort", 4'h1, 4'h0, 1'b0, 2'd3, 1'b0);
        r_in = 1'b0; step(); check("s5_refire_state", 32'(state), 32'h4);
        r_in = 1'b1; step(); expect_dut("s5_fire_abort", 4'h1, 4'h0, 1'b0, 2'd3, 1'b0);
        check("s5_nt_count", 32'(nt_fire_count), 32'd4);
        r_in = 1'b0; a_in = 4'h0; step();

        // Asynchronous reset mid-COLLECT
        a_in = 4'h3; step(); check("s6_pre_state", 32'(state), 32'h2);
        #2 reset_n = 1'b0;
        #1 expect_dut("s6_async", 4'h1, 4'h0, 1'b0, 2'd0, 1'b0);
        check("s6_nt_count", 32'(nt_fire_count), 32'd0);
        reset_n = 1'b1;
        a_in = 4'h0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/abro_multi_fsm.md
# abro_multi_fsm

Parametrised N-input successor to the two-input ABRO controller: waits until every one of N request inputs has been seen at least once (any order, any overlap), then fires output `o`, holds until all inputs drop or an abort arrives, and re-arms. It adds a synchronous abort (`r_in`), an optional collection timeout, a saturating fire counter and a visible `seen` vector. It sits in the same control layer as the two-input machine, driven by synchronous handshake/event lines from neighbouring blocks.

## Interface
- `N`, 4: number of request inputs, legal 2..16.
- `CNT_W`, 8: width of `fire_count`.
- `TIMEOUT`, 0: cycles allowed in COLLECT before abandoning; 0 disables the timeout.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_in`  in  N  request lines, sampled each rising edge.
- `r_in`  in  1  synchronous abort/restart, highest priority.
- `o`  out  1  fire output, decoded from state register only.
- `state`  out  4  one-hot state: IDLE=4'b0001, COLLECT=4'b0010, FIRE=4'b0100, HOLD=4'b1000.
- `seen`  out  N  inputs observed since last re-arm.
- `fire_count`  out  CNT_W  number of FIRE entries, saturating.
- `timeout`  out  1  one-cycle pulse when COLLECT is abandoned.

## Operation
- Reset: `state`=0001, `seen`=0, `fire_count`=0, `timeout`=0, `o`=0, timer=0.
- `r_in`=1 in any state: next state IDLE, `seen`←0, timer←0; `fire_count` untouched; overrides every transition below.
- Let `nxt_seen = seen | a_in`; `all = &nxt_seen`.
- IDLE: `a_in`==0 → stay. Else `seen`←`nxt_seen`; `all` → FIRE, otherwise → COLLECT with timer←1.
- COLLECT: `seen`←`nxt_seen`; `all` → FIRE; else if `TIMEOUT`>0 and timer==`TIMEOUT` → IDLE, `seen`←0, `timeout` pulses; else timer increments.
- FIRE: `fire_count` increments unless all ones; → HOLD unconditionally.
- HOLD: `a_in`==0 → IDLE with `seen`←0; otherwise stay.
- `seen` stays all ones in FIRE and HOLD.
- Timer width clog2(`TIMEOUT`+1); absent when `TIMEOUT`=0.

## Timing
- Every output is registered or decoded from registers; no combinational path from `a_in`/`r_in` to outputs.
- Minimum latency: all N bits high in one IDLE cycle → `state`=FIRE and `o`=1 the cycle after that edge.
- Completion and expiry on the same COLLECT edge: completion wins (FIRE, no `timeout`).
- `timeout` is high exactly one cycle, coincident with `state` returning to IDLE.
- `fire_count` updates on the edge leaving FIRE (visible one cycle after `o` first rises).
- `r_in` on the same edge as completion: IDLE, no FIRE, count unchanged.
- Reset assertion mid-operation forces reset values immediately, independent of `clk`.

## Configuration
- `ABRO_MULTI_STICKY_EN` defined: `o`=1 in FIRE and HOLD (level until re-arm or abort).
- Not defined: `o`=1 in FIRE only (one-cycle pulse per completion).

## Test plan
- Reset then N=4, `a_in`=0001,0010,0100,1000 on consecutive cycles → `state` 0010 after first edge, 0100 after fourth, `o`=1, `seen`=1111, then 1000 with `fire_count`=1.
- `a_in`=1111 in one IDLE cycle → FIRE next cycle; hold `a_in`=1111 three cycles → stays HOLD (`o`=1 sticky / 0 pulse build); `a_in`=0 → IDLE, `seen`=0000.
- `TIMEOUT`=5, `a_in`=0011 once then 0 → COLLECT five cycles, then IDLE with `timeout`=1 one cycle, `fire_count` unchanged.
- `TIMEOUT`=5, final missing bits arrive on the expiry edge → FIRE, `timeout` stays 0.
- `seen`=0111 in COLLECT, `r_in`=1 with `a_in`=1000 → IDLE, `seen`=0000, no FIRE; `r_in` during HOLD → IDLE, `o`=0.
- `CNT_W`=2, four complete fire cycles → `fire_count` 1,2,3,3 (saturates); async `reset_n` low mid-COLLECT → all outputs reset values before next `clk` edge.
